// File: rtl/lcd_pkg.sv
// Shared LCD panel constants and pixel format, used by the timing generator and
// the line buffer.
package lcd_pkg;

  localparam int H_ACTIVE = 480;
  localparam int TDEH     = 480;
  localparam int TDEL     = 256;
  localparam int TDE      = 272;
  localparam int TDEB     = 45;
  localparam int PIX_W    = 3;
  localparam int ADDR_W   = 9;

  // Pixel bit order on the bus is {r,g,b}, r in the MSB.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } pix_t;

endpackage

// File: rtl/lcd_line_buffer_if.sv
// Host-to-buffer pixel stream: valid/ready handshake carrying one {r,g,b} pixel.
interface lcd_line_buffer_if;
  import lcd_pkg::*;

  logic             valid;
  logic [PIX_W-1:0] data;
  logic             ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/lcd_line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port with
// read enable, sized as a power of two so {bank, addr} indexes it directly.
module lcd_line_ram #(
  parameter int AW = 10,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lcd_line_buffer.sv
// Ping-pong line buffer: host fills one bank over a valid/ready stream while the
// panel side drains the other bank on pixel-enable strobes.
module lcd_line_buffer
  import lcd_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            pix_ce,
  input  logic            de_in,
  lcd_line_buffer_if.slave s,
  output logic            r,
  output logic            g,
  output logic            b,
  output logic            de_out,
  output logic            underflow
);

  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              line_ok;
  logic              de_q;
  logic              pix_on;
  logic [PIX_W-1:0]  rd_pix;

  logic wr_fire;
  logic line_start;
  logic line_end;
  logic bank_ok;
  logic rd_hit;

  assign s.ready    = !rst && !full[wr_bank];
  assign wr_fire    = s.valid && s.ready;
  assign line_start = de_in && !de_q;
  assign line_end   = !de_in && de_q;
  // On the first strobe line_ok is not yet loaded, so look at the flag directly.
  assign bank_ok    = line_start ? full[rd_bank] : line_ok;
  assign rd_hit     = pix_ce && de_in && bank_ok && (rd_addr < ADDR_W'(H_ACTIVE));

  lcd_line_ram #(
    .AW (ADDR_W + 1),
    .DW (PIX_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr ({wr_bank, wr_addr}),
    .wdata (s.data),
    .re    (rd_hit),
    .raddr ({rd_bank, rd_addr}),
    .rdata (rd_pix)
  );

  // RAM output register holds the pixel; pix_on blanks strobes that did not read.
  assign {r, g, b} = pix_on ? rd_pix : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      line_ok   <= 1'b0;
      de_q      <= 1'b0;
      de_out    <= 1'b0;
      pix_on    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;

      if (wr_fire) begin
        if (wr_addr == ADDR_W'(H_ACTIVE - 1)) begin
          wr_addr       <= '0;
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end

      if (pix_ce) begin
        de_q   <= de_in;
        de_out <= de_in;
        pix_on <= rd_hit;

        if (line_start) begin
          line_ok   <= full[rd_bank];
          underflow <= !full[rd_bank];
        end

        if (de_in) begin
          if (rd_addr < ADDR_W'(H_ACTIVE)) rd_addr <= rd_addr + 1'b1;
        end else if (line_end) begin
          rd_addr <= '0;
          // A failed line keeps its bank so the next line retries it.
          if (line_ok) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_line_buffer.sv
// Directed bench for lcd_line_buffer: empty lines, buffered lines, bank full,
// long/short DE, random host pacing and mid-line reset.
module tb_lcd_line_buffer;
  import lcd_pkg::*;

  logic clk = 1'b0;
  logic rst, pix_ce, de_in;
  logic r, g, b, de_out, underflow;

  int errors = 0;
  int checks = 0;

  logic [2:0] last_rgb;
  logic       last_de, last_uf, last_ready, pre_de;

  lcd_line_buffer_if s_if ();

  lcd_line_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .pix_ce    (pix_ce),
    .de_in     (de_in),
    .s         (s_if),
    .r         (r),
    .g         (g),
    .b         (b),
    .de_out    (de_out),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] pat_pix(input int pat, input int i);
    return 3'((i + 3 * pat) % 8);
  endfunction

  // One pixel-enable strobe followed by gap idle clocks; outputs are captured
  // just before and just after the strobe edge.
  task automatic strobe(input logic de, input int gap);
    pix_ce = 1'b1;
    de_in  = de;
    #1;
    pre_de = de_out;
    @(posedge clk); #1;
    last_rgb   = {r, g, b};
    last_de    = de_out;
    last_uf    = underflow;
    last_ready = s_if.ready;
    pix_ce = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic push_line(input int pat, input int max_gap, output int stalls);
    stalls = 0;
    for (int i = 0; i < H_ACTIVE; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = pat_pix(pat, i);
      while (!s_if.ready) begin
        @(posedge clk); #1;
        stalls++;
        if (stalls > 20000) begin
          checks++;
          errors++;
          $error("FAIL host_timeout: observed=stalled expected=ready pattern=%0d pixel=%0d", pat, i);
          s_if.valid = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
      s_if.valid = 1'b0;
      repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
    end
  endtask

  // pat < 0 means the line is expected black.
  task automatic run_line(input int n_de, input int gap, input int pat,
                          output int uf_cnt, output int bad, output int lit);
    int de_err;
    logic [2:0] exp;
    de_err = 0; uf_cnt = 0; bad = 0; lit = 0;
    for (int i = 0; i < n_de; i++) begin
      strobe(1'b1, gap);
      exp = (pat < 0 || i >= H_ACTIVE) ? 3'd0 : pat_pix(pat, i);
      if (last_rgb !== exp) bad++;
      if (last_rgb !== 3'd0) lit++;
      if (last_uf) uf_cnt++;
      if (last_de !== 1'b1 || pre_de !== (i != 0)) de_err++;
    end
    check("de_out_active", de_err, 0);
  endtask

  task automatic blank(input int n, input int gap, output logic rdy_first);
    int err;
    err = 0;
    rdy_first = 1'b0;
    for (int i = 0; i < n; i++) begin
      strobe(1'b0, gap);
      if (i == 0) rdy_first = last_ready;
      if (pre_de !== (i == 0)) err++;
      if (last_rgb !== 3'd0 || last_de !== 1'b0 || last_uf !== 1'b0) err++;
    end
    check("blanking", err, 0);
  endtask

  initial begin
    int uf, bad, lit, stalls, shown, next_pat;
    logic rdy;

    rst = 1'b1; pix_ce = 1'b0; de_in = 1'b0;
    s_if.valid = 1'b0; s_if.data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", s_if.ready, 0);
    check("rst_rgb", {r, g, b}, 0);
    check("rst_de_out", de_out, 0);
    check("rst_underflow", underflow, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", s_if.ready, 1);

    // Nothing buffered: two black lines, one underflow each.
    repeat (2) begin
      run_line(H_ACTIVE, 5, -1, uf, bad, lit);
      check("empty_underflow", uf, 1);
      check("empty_black", lit, 0);
      blank(4, 5, rdy);
    end

    // One buffered line, other bank still free.
    push_line(0, 0, stalls);
    check("line_a_stalls", stalls, 0);
    check("ready_bank1_empty", s_if.ready, 1);
    run_line(H_ACTIVE, 5, 0, uf, bad, lit);
    check("line_a_underflow", uf, 0);
    check("line_a_pixels", bad, 0);
    blank(4, 5, rdy);

    // Both banks full, then released by the first line's DE fall.
    push_line(1, 0, stalls);
    check("line_b_stalls", stalls, 0);
    push_line(2, 0, stalls);
    check("line_c_stalls", stalls, 0);
    check("ready_both_full", s_if.ready, 0);
    run_line(H_ACTIVE, 5, 1, uf, bad, lit);
    check("line_b_underflow", uf, 0);
    check("line_b_pixels", bad, 0);
    check("ready_before_release", s_if.ready, 0);
    blank(4, 5, rdy);
    check("ready_after_release", rdy, 1);

    // DE longer than the line: tail is black, bank still released.
    run_line(500, 5, 2, uf, bad, lit);
    check("long_de_underflow", uf, 0);
    check("long_de_pixels", bad, 0);
    blank(4, 5, rdy);
    run_line(H_ACTIVE, 5, -1, uf, bad, lit);
    check("after_long_underflow", uf, 1);
    check("after_long_black", lit, 0);
    blank(4, 5, rdy);

    // Short DE line: remaining pixels dropped, bank released.
    push_line(3, 0, stalls);
    run_line(100, 5, 3, uf, bad, lit);
    check("short_de_underflow", uf, 0);
    check("short_de_pixels", bad, 0);
    blank(4, 5, rdy);
    run_line(H_ACTIVE, 5, -1, uf, bad, lit);
    check("after_short_underflow", uf, 1);
    check("after_short_black", lit, 0);
    blank(4, 5, rdy);

    // Host slower than display, pix_ce every clock: each line whole or black.
    shown = 0;
    next_pat = 4;
    fork
      begin
        for (int p = 4; p < 7; p++) push_line(p, 2, stalls);
      end
      begin
        for (int l = 0; l < 14; l++) begin
          run_line(H_ACTIVE, 0, next_pat, uf, bad, lit);
          check("rand_line_whole", ((uf == 1 && lit == 0) || (uf == 0 && bad == 0)), 1);
          if (uf == 0) begin
            shown++;
            next_pat++;
          end
          blank(20, 0, rdy);
        end
      end
    join
    check("rand_lines_shown", shown, 3);

    // Reset in the middle of a line discards everything.
    push_line(7, 0, stalls);
    run_line(200, 5, 7, uf, bad, lit);
    check("pre_rst_pixels", bad, 0);
    rst = 1'b1; pix_ce = 1'b1; de_in = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_rgb", {r, g, b}, 0);
    check("mid_rst_de_out", de_out, 0);
    check("mid_rst_underflow", underflow, 0);
    rst = 1'b0; pix_ce = 1'b0;
    #1;
    check("mid_rst_ready", s_if.ready, 1);
    repeat (5) begin @(posedge clk); #1; end
    run_line(H_ACTIVE - 201, 5, -1, uf, bad, lit);
    check("post_rst_tail_underflow", uf, 1);
    check("post_rst_tail_black", lit, 0);
    blank(4, 5, rdy);
    run_line(H_ACTIVE, 5, -1, uf, bad, lit);
    check("post_rst_line_underflow", uf, 1);
    check("post_rst_line_black", lit, 0);
    blank(4, 5, rdy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
